// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared types for the AXI4-Lite slave memory.
// Response codes, FSM states, LFSR seed and the byte-merge helper.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_t;

  localparam int MAX_DW = 64;
  localparam int MAX_SW = MAX_DW / 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Replace the bytes of old_w whose strobe is set with those of new_w.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_SW-1:0] strb
  );
    logic [MAX_DW-1:0] res;
    for (int i = 0; i < MAX_SW; i++) begin
      res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_stall_lfsr.sv
// axi4_lite_stall_lfsr: pseudo-random ready stall generator.
// Only instantiated when AXI_SLV_STALL_EN is defined.
import axi4_lite_pkg::*;

module axi4_lite_stall_lfsr (
  input  logic clk,
  input  logic rst,
  output logic stall
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci step, taps 16,14,13,11 (maximal length).
  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, reseeded by rst.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// axi4_lite_slave_mem: parametrised AXI4-Lite slave memory.
// Define AXI_SLV_STALL_EN to add LFSR-driven ready stalls.
import axi4_lite_pkg::*;

module axi4_lite_slave_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [3:0]          s_awcache,
  input  logic [2:0]          s_awprot,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [3:0]          s_arcache,
  input  logic [2:0]          s_arprot,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [3:0] LAT_LOAD =
    4'(RD_LAT > 0 ? RD_LAT - 1 : 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              stall;

  // Write channel state.
  w_state_t          w_state_q, w_state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  axi_resp_t         bresp_q, bresp_d;

  // Read channel state.
  r_state_t          r_state_q, r_state_d;
  logic [IDX_W-1:0]  ar_idx_q, ar_idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  axi_resp_t         rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Datapath helpers.
  logic              aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_data, wr_merged, rd_word;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_en, wr_ok, rd_ok, rd_sample;

  logic unused_ok;
  assign unused_ok = ^{s_awcache, s_awprot, s_arcache, s_arprot,
                       s_awaddr[OFF-1:0], s_araddr[OFF-1:0]};

`ifdef AXI_SLV_STALL_EN
  axi4_lite_stall_lfsr u_stall (
    .clk   (clk),
    .rst   (rst),
    .stall (stall)
  );
`else
  assign stall = 1'b0;
`endif

  assign s_awready = awready_q & ~stall;
  assign s_wready  = wready_q & ~stall;
  assign s_arready = arready_q & ~stall;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  // Select the beat being committed (held or arriving now) and merge it.
  always_comb begin
    aw_hs   = s_awvalid & s_awready;
    w_hs    = s_wvalid & s_wready;
    wr_idx  = aw_done_q ? aw_idx_q : s_awaddr[ADDR_W-1:OFF];
    wr_data = w_done_q ? wdata_q : s_wdata;
    wr_strb = w_done_q ? wstrb_q : s_wstrb;
    wr_ok   = wr_idx < DEPTH_IDX;
    wr_en   = !rst && (w_state_q == W_IDLE) &&
              (aw_done_q || aw_hs) && (w_done_q || w_hs);
    wr_merged = DATA_W'(byte_merge(
                  MAX_DW'(mem[wr_idx[MEM_AW-1:0]]),
                  MAX_DW'(wr_data),
                  MAX_SW'(wr_strb)));
  end

  // Write FSM next state: gather AW and W, commit, hold B.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          aw_idx_d  = s_awaddr[ADDR_W-1:OFF];
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if (wr_en) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? OKAY : SLVERR;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !w_done_d;
  end

  // Write channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_idx[MEM_AW-1:0]] <= wr_merged;
  end

  // Read sample point and write-first bypass on same-word collision.
  always_comb begin
    ar_hs  = s_arvalid & s_arready;
    rd_idx = (r_state_q == R_IDLE) ? s_araddr[ADDR_W-1:OFF]
                                   : ar_idx_q;
    rd_ok  = rd_idx < DEPTH_IDX;
    rd_sample = ((r_state_q == R_IDLE) && ar_hs && (RD_LAT == 0)) ||
                ((r_state_q == R_WAIT) && (cnt_q == 4'd0));
    if (wr_en && wr_ok && (wr_idx == rd_idx)) rd_word = wr_merged;
    else rd_word = mem[rd_idx[MEM_AW-1:0]];
  end

  // Read FSM next state: accept AR, wait RD_LAT, hold R.
  always_comb begin
    r_state_d = r_state_q;
    ar_idx_d  = ar_idx_q;
    cnt_d     = cnt_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          ar_idx_d  = s_araddr[ADDR_W-1:OFF];
          cnt_d     = LAT_LOAD;
          r_state_d = (RD_LAT == 0) ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt_q == 4'd0) r_state_d = R_DATA;
        else cnt_d = cnt_q - 4'd1;
      end
      R_DATA: begin
        if (s_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rd_sample) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_ok ? OKAY : SLVERR;
      rdata_d  = rd_ok ? rd_word : '0;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  // Read channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      ar_idx_q  <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_idx_q  <= ar_idx_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// tb_axi4_lite_slave_mem: randomized bench for the AXI4-Lite slave memory.
// Expected values come from a word-array model of the memory map.
module tb_axi4_lite_slave_mem;

  localparam int DEPTH = 64;
  localparam int LAT   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awcache;
  logic [2:0]  s_awprot;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arcache;
  logic [2:0]  s_arprot;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] model [DEPTH];

  axi4_lite_slave_mem #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awcache (s_awcache),
    .s_awprot  (s_awprot),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arcache (s_arcache),
    .s_arprot  (s_arprot),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: word map with byte enables, SLVERR past the end.
  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return (a / 4 < DEPTH) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return (a / 4 < DEPTH) ? model[a / 4] : 32'h0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    if (a / 4 < DEPTH)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_write(input logic [31:0] addr,
                           input logic [31:0] data,
                           input logic [3:0] strb,
                           input int d_aw, input int d_w,
                           input int hold,
                           output logic [1:0] resp);
    bit aw_ok, w_ok, aw_now, w_now, stable;
    int t;
    aw_ok = 0; w_ok = 0; t = 0; resp = 2'b11;
    while (!(aw_ok && w_ok) && t < 200) begin
      @(negedge clk);
      s_awaddr  = addr;
      s_wdata   = data;
      s_wstrb   = strb;
      s_awvalid = !aw_ok && (t >= d_aw);
      s_wvalid  = !w_ok && (t >= d_w);
      aw_now = s_awvalid && s_awready;
      w_now  = s_wvalid && s_wready;
      @(posedge clk);
      aw_ok |= aw_now;
      w_ok  |= w_now;
      t++;
    end
    @(negedge clk);
    s_awvalid = 0;
    s_wvalid  = 0;
    if (!(aw_ok && w_ok)) begin
      chk("aw_w_timeout", 0, 1);
      return;
    end
    t = 0;
    while (!s_bvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_bvalid) begin
      chk("b_timeout", 0, 1);
      return;
    end
    resp = s_bresp;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      s_awvalid = 1;
      s_awaddr  = addr ^ 32'h4;
      @(negedge clk);
      if (!s_bvalid || s_bresp !== resp || s_awready) stable = 0;
    end
    s_awvalid = 0;
    if (hold > 0) chk("b_hold_stable", stable, 1);
    s_bready = 1;
    @(posedge clk);
    @(negedge clk);
    s_bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data,
                          output logic [1:0] resp,
                          output int lat);
    bit ok, stable;
    int t;
    ok = 0; t = 0; lat = 0; data = '0; resp = 2'b11;
    while (!ok && t < 200) begin
      @(negedge clk);
      s_arvalid = 1;
      s_araddr  = addr;
      ok = s_arready;
      @(posedge clk);
      t++;
    end
    if (!ok) begin
      @(negedge clk);
      s_arvalid = 0;
      chk("ar_timeout", 0, 1);
      return;
    end
    do begin
      @(negedge clk);
      s_arvalid = 0;
      lat++;
    end while (!s_rvalid && lat < 100);
    if (!s_rvalid) begin
      chk("r_timeout", 0, 1);
      return;
    end
    data = s_rdata;
    resp = s_rresp;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      s_arvalid = 1;
      s_araddr  = addr ^ 32'h4;
      @(negedge clk);
      if (!s_rvalid || s_rdata !== data || s_rresp !== resp ||
          s_arready) stable = 0;
    end
    s_arvalid = 0;
    if (hold > 0) chk("r_hold_stable", stable, 1);
    s_rready = 1;
    @(posedge clk);
    @(negedge clk);
    s_rready = 0;
  endtask

  // Write then read back one address, checking against the model.
  task automatic wr_rd(input string tag, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input int d_aw, input int d_w);
    logic [1:0]  br, rr;
    logic [31:0] rd;
    int          lat;
    axi_write(a, d, s, d_aw, d_w, 0, br);
    m_write(a, d, s);
    chk({tag, "_bresp"}, br, m_resp(a));
    axi_read(a, 0, rd, rr, lat);
    chk({tag, "_rdata"}, rd, m_read(a));
    chk({tag, "_rresp"}, rr, m_resp(a));
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd, a, d;
    logic [3:0]  s;
    int          lat;
    bit          seen;
    int          t;

    rst = 1;
    s_awaddr = 0; s_awcache = 0; s_awprot = 0; s_awvalid = 0;
    s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arcache = 0; s_arprot = 0; s_arvalid = 0;
    s_rready = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {s_awready, s_wready, s_arready}, 3'b000);
    chk("rst_valid", {s_bvalid, s_rvalid}, 2'b00);
    chk("rst_resp", {s_bresp, s_rresp}, 4'b0000);
    chk("rst_rdata", s_rdata, 32'h0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", {s_awready, s_wready, s_arready}, 3'b111);

    // Give every word a known value so the model starts defined.
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      axi_write(32'(i * 4), d, 4'hF, 0, 0, 0, br);
      m_write(32'(i * 4), d, 4'hF);
      chk("init_bresp", br, 2'b00);
    end

    // Same-cycle AW/W, readback and read latency.
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
    m_write(32'h10, 32'hDEADBEEF, 4'hF);
    chk("t1_bresp", br, 2'b00);
    axi_read(32'h10, 0, rd, rr, lat);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_rresp", rr, 2'b00);
    chk("t1_latency", 32'(lat), 32'(LAT + 1));

    // W leads AW, then AW leads W.
    wr_rd("t2_wlead", 32'h20, 32'hCAFE0001, 4'hF, 3, 0);
    wr_rd("t2_awlead", 32'h24, 32'hCAFE0002, 4'hF, 0, 3);
    axi_read(32'h20, 0, rd, rr, lat);
    chk("t2_recheck", rd, 32'hCAFE0001);

    // Partial strobe merge.
    wr_rd("t3_full", 32'h40, 32'h11223344, 4'hF, 0, 0);
    wr_rd("t3_part", 32'h40, 32'hAABBCCDD, 4'b0101, 1, 0);
    axi_read(32'h40, 0, rd, rr, lat);
    chk("t3_merge", rd, 32'h11BB33DD);

    // First out-of-range word, word 0 untouched.
    wr_rd("t4_oor", 32'(DEPTH * 4), 32'h55AA55AA, 4'hF, 0, 0);
    axi_read(32'h0, 0, rd, rr, lat);
    chk("t4_word0", rd, m_read(32'h0));

    // Backpressure on B and R for 20 cycles.
    axi_write(32'h30, 32'h0BADF00D, 4'hF, 0, 0, 20, br);
    m_write(32'h30, 32'h0BADF00D, 4'hF);
    chk("t5_bresp", br, 2'b00);
    axi_read(32'h30, 20, rd, rr, lat);
    chk("t5_rdata", rd, 32'h0BADF00D);

    // Write commit lands on the read sample edge: new data wins.
    @(posedge clk);
    #1;
    fork
      axi_read(32'h50, 0, rd, rr, lat);
      begin
        repeat (LAT) @(posedge clk);
        axi_write(32'h50, 32'h600DD00D, 4'hF, 0, 0, 0, br);
      end
    join
    m_write(32'h50, 32'h600DD00D, 4'hF);
    chk("coll_rdata", rd, 32'h600DD00D);

    // Reset while the read is waiting: no response, then recovery.
    seen = 0;
    @(negedge clk);
    s_arvalid = 1;
    s_araddr  = 32'h10;
    t = 0;
    while (!s_arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t6_ar_accept", s_arready, 1);
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 0;
    repeat (2) begin
      @(negedge clk);
      seen |= s_rvalid;
    end
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      seen |= s_rvalid;
    end
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen |= s_rvalid;
      if (i == 1) chk("t6_arready", s_arready, 1);
    end
    chk("t6_no_rvalid", seen, 0);
    axi_read(32'h10, 0, rd, rr, lat);
    chk("t6_rdata", rd, m_read(32'h10));
    chk("t6_rresp", rr, 2'b00);

    // Randomized mix against the model.
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, DEPTH + 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                  0, br);
        m_write(a, d, s);
        chk("rnd_bresp", br, m_resp(a));
      end else begin
        axi_read(a, 0, rd, rr, lat);
        chk("rnd_rdata", rd, m_read(a));
        chk("rnd_rresp", rr, m_resp(a));
        chk("rnd_lat", 32'(lat), 32'(LAT + 1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
